// File: rtl/channel_llr_buffer_if.sv
// Channel LLR buffer bus: serial LLR load, frame-done handshake and one-hot row read port.
interface channel_llr_buffer_if #(
  parameter int n = 3,
  parameter int p = 1,
  parameter int Q = 6
) ();
  logic [Q-1:0]            llr_in;
  logic                    llr_valid;
  logic                    llr_ready;
  logic                    decoder_done;
  logic                    channel_register_ready;
  logic                    channel_register_rd_en;
  logic [2**(n-p-1)-1:0]   channel_register_addr;
  logic [Q*2**(p+1)-1:0]   channel_register_data;
  logic                    rd_err;

  modport slave (
    input  llr_in, llr_valid, decoder_done, channel_register_rd_en, channel_register_addr,
    output llr_ready, channel_register_ready, channel_register_data, rd_err
  );

  modport master (
    output llr_in, llr_valid, decoder_done, channel_register_rd_en, channel_register_addr,
    input  llr_ready, channel_register_ready, channel_register_data, rd_err
  );
endinterface

// File: rtl/channel_llr_buffer.sv
// Collects one frame of 2**n serial channel LLRs into a bit-reversed register file
// and serves one-hot row reads to the SC decoder datapath.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_LOAD | accepting samples; count_q is the next sample index k
//   ST_FULL | frame complete, storage frozen until decoder_done
module channel_llr_buffer #(
  parameter int n = 3,
  parameter int p = 1,
  parameter int Q = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  channel_llr_buffer_if.slave     bus
);

  localparam int N = 2**n;
  localparam int L = 2**(p+1);
  localparam int R = 2**(n-p-1);
  localparam logic [n-1:0] CNT_LAST = {n{1'b1}};

  typedef enum logic {ST_LOAD = 1'b0, ST_FULL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [n-1:0]           count_q, count_d;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;
  logic [L*Q-1:0]         data_q, data_d;
  logic [N-1:0][Q-1:0]    mem_q;

  logic                   wr_en;
  logic [n-1:0]           wr_idx;
  logic                   addr_onehot;
  logic [L*Q-1:0]         row_data;

  function automatic logic [n-1:0] bitrev(input logic [n-1:0] k);
    logic [n-1:0] b;
    for (int i = 0; i < n; i++) b[i] = k[n-1-i];
    return b;
  endfunction

  assign wr_idx = bitrev(count_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ready_d = ready_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (bus.llr_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == CNT_LAST) begin
            state_d = ST_FULL;
            ready_d = 1'b1;
          end
        end
      end
      ST_FULL: begin
        // llr_ready is low here, so a same-cycle llr_valid is never a transfer
        if (bus.decoder_done) begin
          state_d = ST_LOAD;
          ready_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= bus.llr_in;
    end
  end

  assign addr_onehot = (bus.channel_register_addr != '0) &&
                       ((bus.channel_register_addr & (bus.channel_register_addr - 1'b1)) == '0);

  always_comb begin
    row_data = '0;
    for (int r = 0; r < R; r++) begin
      if (bus.channel_register_addr[r]) row_data = row_data | mem_q[r*L +: L];
    end
  end

  always_comb begin
    data_d = data_q;
    err_d  = err_q;
    if (bus.channel_register_rd_en) begin
      // reads in LOAD still return the partial row but are flagged
      if (addr_onehot) data_d = row_data;
      if (!addr_onehot || state_q != ST_FULL) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign bus.llr_ready              = (state_q == ST_LOAD);
  assign bus.channel_register_ready = ready_q;
  assign bus.channel_register_data  = data_q;
  assign bus.rd_err                 = err_q;

endmodule

// File: tb/tb_channel_llr_buffer.sv
// Scoreboard bench for channel_llr_buffer with n=3, p=1, Q=6.
module tb_channel_llr_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  channel_llr_buffer_if #(.n(3), .p(1), .Q(6)) bus ();

  channel_llr_buffer #(.n(3), .p(1), .Q(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int wr_k  = 0;
  logic signed [5:0] ref_mem [8];
  logic [23:0] exp_q [$];
  logic [23:0] last_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pack4(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  function automatic logic [23:0] ref_row(input int r);
    return {ref_mem[r*4+3], ref_mem[r*4+2], ref_mem[r*4+1], ref_mem[r*4]};
  endfunction

  function automatic int brev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.llr_valid = 1'b0;
    bus.llr_in = '0;
    bus.decoder_done = 1'b0;
    bus.channel_register_rd_en = 1'b0;
    bus.channel_register_addr = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    wr_k = 0;
    last_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // pre: channel_register_ready as seen in the cycle the sample was offered
  task automatic send(input int val, input bit gap, output logic pre);
    logic acc;
    acc = 1'b0;
    pre = 1'bx;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      bus.llr_valid = 1'b1;
      bus.llr_in = 6'(val);
      acc = bus.llr_ready;
      pre = bus.channel_register_ready;
      @(posedge clk);
    end
    check_eq("send_accept", 32'(acc), 32'(1));
    if (acc) begin
      ref_mem[brev3(wr_k)] = 6'(val);
      wr_k = (wr_k + 1) % 8;
    end
    if (gap) begin
      @(negedge clk);
      bus.llr_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic load_frame(input int base, input int step, input bit gap);
    logic pre;
    for (int k = 0; k < 8; k++) begin
      send(base + step * k, gap, pre);
      if (k == 7) check_eq("rdy_before_8th", 32'(pre), 32'(0));
    end
    @(negedge clk);
    bus.llr_valid = 1'b0;
    check_eq("rdy_after_8th", 32'(bus.channel_register_ready), 32'(1));
    check_eq("llr_ready_full", 32'(bus.llr_ready), 32'(0));
  endtask

  task automatic rd(input logic [1:0] addr, input logic [23:0] exp, input bit with_done);
    @(negedge clk);
    bus.llr_valid = with_done;
    bus.llr_in = 6'd20;
    bus.decoder_done = with_done;
    bus.channel_register_rd_en = 1'b1;
    bus.channel_register_addr = addr;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    bus.channel_register_rd_en = 1'b0;
    bus.decoder_done = 1'b0;
    bus.llr_valid = 1'b0;
    check_eq($sformatf("rd_data_a%b", addr), 32'(bus.channel_register_data), 32'(exp_q.pop_front()));
    last_data = exp;
  endtask

  initial begin
    logic pre;
    rst_n = 1'b0;
    do_reset();
    check_eq("rst_llr_ready", 32'(bus.llr_ready), 32'(1));
    check_eq("rst_ready", 32'(bus.channel_register_ready), 32'(0));
    check_eq("rst_data", 32'(bus.channel_register_data), 32'(0));
    check_eq("rst_rd_err", 32'(bus.rd_err), 32'(0));

    // back-to-back frame 0..7
    load_frame(0, 1, 1'b0);
    rd(2'b01, pack4(0, 4, 2, 6), 1'b0);
    rd(2'b10, pack4(1, 5, 3, 7), 1'b0);
    check_eq("t1_rd_err", 32'(bus.rd_err), 32'(0));
    @(negedge clk);
    check_eq("t1_data_hold", 32'(bus.channel_register_data), 32'(last_data));

    // valid held in FULL must be ignored
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.llr_valid = 1'b1;
      bus.llr_in = 6'd31;
      check_eq("t2_llr_ready", 32'(bus.llr_ready), 32'(0));
    end
    rd(2'b01, pack4(0, 4, 2, 6), 1'b0);
    rd(2'b10, pack4(1, 5, 3, 7), 1'b0);

    // decoder_done with same-cycle read and valid: pre-transition data, sample dropped
    rd(2'b01, pack4(0, 4, 2, 6), 1'b1);
    check_eq("t3_ready_low", 32'(bus.channel_register_ready), 32'(0));
    check_eq("t3_llr_ready", 32'(bus.llr_ready), 32'(1));
    load_frame(8, 1, 1'b0);
    rd(2'b01, pack4(8, 12, 10, 14), 1'b0);
    rd(2'b10, pack4(9, 13, 11, 15), 1'b0);
    check_eq("t3_rd_err", 32'(bus.rd_err), 32'(0));

    // illegal addresses
    rd(2'b11, last_data, 1'b0);
    check_eq("t4_err_multi", 32'(bus.rd_err), 32'(1));
    rd(2'b00, last_data, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("t4_err_sticky", 32'(bus.rd_err), 32'(1));

    // reset mid-load discards partial frame
    @(negedge clk);
    bus.decoder_done = 1'b1;
    @(negedge clk);
    bus.decoder_done = 1'b0;
    for (int k = 0; k < 5; k++) send(21 + k, 1'b0, pre);
    do_reset();
    check_eq("t5_rd_err_clr", 32'(bus.rd_err), 32'(0));
    check_eq("t5_ready", 32'(bus.channel_register_ready), 32'(0));
    check_eq("t5_data", 32'(bus.channel_register_data), 32'(0));
    load_frame(30, -3, 1'b0);
    rd(2'b01, ref_row(0), 1'b0);
    rd(2'b10, ref_row(1), 1'b0);
    rd(2'b01, pack4(30, 18, 24, 12), 1'b0);

    // release, read partial frame in LOAD, then gap-toggled negative frame
    @(negedge clk);
    bus.decoder_done = 1'b1;
    @(negedge clk);
    bus.decoder_done = 1'b0;
    check_eq("t6_err_clean", 32'(bus.rd_err), 32'(0));
    rd(2'b01, ref_row(0), 1'b0);
    check_eq("t6_err_load_rd", 32'(bus.rd_err), 32'(1));
    load_frame(-8, 1, 1'b1);
    rd(2'b01, pack4(-8, -4, -6, -2), 1'b0);
    rd(2'b10, pack4(-7, -3, -5, -1), 1'b0);
    rd(2'b10, ref_row(1), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
